stage3: RTL
===========

STAGE3 -- requirements
Module: stage3

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-low.
REQ-003 A_sel  input  3  A source select, delayed one cycle by idle stage 2.5.
REQ-004 A_en  input  1  A write enable, already qualified with valid upstream.
REQ-005 X_sel  input  3  X source select.
REQ-006 X_en  input  1  X write enable, already qualified with valid.
REQ-007 valid  input  1  instruction present in stage3 this cycle.
REQ-008 imm  input  32  instruction immediate (k).
REQ-009 alu_result  input  32  ALU output for this instruction.
REQ-010 packet_data  input  32  packet memory read data, zero-extended.
REQ-011 packet_len  input  32  current packet length in bytes.
REQ-012 scratch_addr  input  4  scratch word index (k[3:0]).
REQ-013 scratch_wr  input  1  store to scratch this cycle.
REQ-014 scratch_src  input  1  store source: 0 = A, 1 = X.
REQ-015 A  output  32  accumulator register.
REQ-016 X  output  32  index register.
REQ-017 scratch_rd_data  output  32  combinational read of scratch[scratch_addr].
REQ-018 retired  output  32  count of valid instructions retired.

Function
REQ-019 A_sel decode shall be: 000 imm, 001 packet_data, 010 packet_len, 011 scratch[scratch_addr], 100 alu_result, 101 X, 110/111 hold A.
REQ-020 X_sel decode shall be: 000 imm, 001 packet_data, 010 packet_len, 011 scratch[scratch_addr], 100 A, 101 MSH = {packet_data[3:0], 2'b00} zero-extended, 110/111 hold X.
REQ-021 A shall load its selected source on the rising edge where A_en && valid; otherwise it holds.
REQ-022 X shall load its selected source on the rising edge where X_en && valid; otherwise it holds.
REQ-023 Latency: the new A/X value shall be visible on the outputs the cycle after the enabling edge, with no combinational bypass.
REQ-024 When A and X are written in the same cycle, each shall use the other's pre-edge value, so A<-X with X<-A is a clean swap.
REQ-025 scratch[scratch_addr] shall be written on the edge where scratch_wr && valid, using the pre-edge A or X per scratch_src.
REQ-026 A scratch read and write to the same address in the same cycle shall return the old contents (read-before-write).
REQ-027 A write of A or X and a scratch store in the same cycle shall store the pre-edge register value.
REQ-028 retired shall increment by 1 on every edge with valid=1 and saturate at 0xFFFFFFFF without wrapping.
REQ-029 Enables with valid=0 shall change no state.
REQ-030 The stage shall never stall and shall accept one instruction per cycle.

Reset
REQ-031 While rst=0: A=0, X=0, retired=0, all 16 scratch words=0, taking effect immediately without waiting for clk.
REQ-032 Reset asserted mid-instruction shall discard that instruction, including its scratch write and retire count.
REQ-033 On rst deassertion, the first edge shall process inputs normally.

Structure
REQ-034 Sel encodings, data width (32), and scratch depth/address width (16/4) shall be defined in shared package bpf_pkg, used also by stage2 and idle_stage2_point_5.
REQ-035 Scratch storage shall be sub-module bpf_scratch_mem (16x32, async-reset, async read, one sync write port).

Verification
REQ-036 Reset then valid=1, A_en=1, A_sel=000, imm=0x12345678 -> A=0x12345678 next cycle; retired=1.
REQ-037 A=5, X=9; A_en=X_en=1, A_sel=101, X_sel=100, valid=1 -> A=9, X=5.
REQ-038 A=0xAA; scratch_wr=1, src=0, addr=3, plus A_en with A_sel=011, addr=3 (old scratch[3]=0) -> A=0, scratch[3]=0xAA.
REQ-039 X_sel=101, packet_data=0x0000004F, X_en=valid=1 -> X=0x3C.
REQ-040 A_en=1, valid=0, A_sel=000, imm=7 -> A unchanged, retired unchanged.
REQ-041 retired preloaded to 0xFFFFFFFE, three valid cycles -> 0xFFFFFFFF held; then rst=0 mid-cycle -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/bpf_pkg.sv
`default_nettype none
//==============================================================================
// Module : bpf_pkg
// Desc   : Shared widths, scratch geometry and source-select encodings.
// Rev    : 1.0  initial release
//==============================================================================
package bpf_pkg;

    localparam int C_DATA_W    = 32;
    localparam int C_SCR_DEPTH = 16;
    localparam int C_SCR_AW    = 4;

    typedef enum logic [2:0] {
        A_SEL_IMM   = 3'b000,
        A_SEL_PKT   = 3'b001,
        A_SEL_LEN   = 3'b010,
        A_SEL_SCR   = 3'b011,
        A_SEL_ALU   = 3'b100,
        A_SEL_X     = 3'b101,
        A_SEL_HOLD0 = 3'b110,
        A_SEL_HOLD1 = 3'b111
    } a_sel_e;

    typedef enum logic [2:0] {
        X_SEL_IMM   = 3'b000,
        X_SEL_PKT   = 3'b001,
        X_SEL_LEN   = 3'b010,
        X_SEL_SCR   = 3'b011,
        X_SEL_A     = 3'b100,
        X_SEL_MSH   = 3'b101,
        X_SEL_HOLD0 = 3'b110,
        X_SEL_HOLD1 = 3'b111
    } x_sel_e;

    // IP header length: low nibble of the packet byte scaled to bytes (x4)
    function automatic logic [C_DATA_W-1:0] msh(input logic [3:0] nib);
        return {{(C_DATA_W-6){1'b0}}, nib, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/stage3_if.sv
`default_nettype none
//==============================================================================
// Module : stage3_if
// Desc   : Instruction-control and register-file bundle for the writeback stage.
// Rev    : 1.0  initial release
//==============================================================================
interface stage3_if;
    import bpf_pkg::*;

    logic [2:0]          A_sel;
    logic                A_en;
    logic [2:0]          X_sel;
    logic                X_en;
    logic                valid;
    logic [C_DATA_W-1:0] imm;
    logic [C_DATA_W-1:0] alu_result;
    logic [C_DATA_W-1:0] packet_data;
    logic [C_DATA_W-1:0] packet_len;
    logic [C_SCR_AW-1:0] scratch_addr;
    logic                scratch_wr;
    logic                scratch_src;
    logic [C_DATA_W-1:0] A;
    logic [C_DATA_W-1:0] X;
    logic [C_DATA_W-1:0] scratch_rd_data;
    logic [C_DATA_W-1:0] retired;

    modport master (
        output A_sel, A_en, X_sel, X_en, valid, imm, alu_result,
               packet_data, packet_len, scratch_addr, scratch_wr, scratch_src,
        input  A, X, scratch_rd_data, retired
    );

    modport slave (
        input  A_sel, A_en, X_sel, X_en, valid, imm, alu_result,
               packet_data, packet_len, scratch_addr, scratch_wr, scratch_src,
        output A, X, scratch_rd_data, retired
    );

endinterface
`default_nettype wire

// File: rtl/bpf_scratch_mem.sv
`default_nettype none
//==============================================================================
// Module : bpf_scratch_mem
// Desc   : 16x32 scratch memory, async reset, async read, one sync write port.
// Rev    : 1.0  initial release
//==============================================================================
module bpf_scratch_mem
    import bpf_pkg::*;
(
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic [C_SCR_AW-1:0] i_rd_addr,
    input  wire logic                i_wr_en,
    input  wire logic [C_SCR_AW-1:0] i_wr_addr,
    input  wire logic [C_DATA_W-1:0] i_wr_data,
    output logic      [C_DATA_W-1:0] o_rd_data
);

    logic [C_DATA_W-1:0] r_mem [C_SCR_DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < C_SCR_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read is purely combinational, so a same-cycle write is seen only after the edge
    assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/stage3.sv
`default_nettype none
//==============================================================================
// Module : stage3
// Desc   : Writeback stage: A/X register loads, scratch stores, retire counter.
// Rev    : 1.0  initial release
//==============================================================================
module stage3
    import bpf_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst,
    stage3_if.slave   bus
);

    logic [C_DATA_W-1:0] r_a;
    logic [C_DATA_W-1:0] r_x;
    logic [C_DATA_W-1:0] r_retired;
    logic [C_DATA_W-1:0] w_a_next;
    logic [C_DATA_W-1:0] w_x_next;
    logic [C_DATA_W-1:0] w_scr_rd;
    logic [C_DATA_W-1:0] w_scr_wdata;
    logic                w_ld_a;
    logic                w_ld_x;
    logic                w_scr_we;

    assign w_ld_a      = bus.A_en & bus.valid;
    assign w_ld_x      = bus.X_en & bus.valid;
    assign w_scr_we    = bus.scratch_wr & bus.valid;
    assign w_scr_wdata = bus.scratch_src ? r_x : r_a;

    bpf_scratch_mem u_scratch (
        .clk       (clk),
        .rst       (rst),
        .i_rd_addr (bus.scratch_addr),
        .i_wr_en   (w_scr_we),
        .i_wr_addr (bus.scratch_addr),
        .i_wr_data (w_scr_wdata),
        .o_rd_data (w_scr_rd)
    );

    // Both muxes see only pre-edge register values, which makes A<->X a clean swap
    always_comb begin
        w_a_next = r_a;
        case (bus.A_sel)
            A_SEL_IMM: w_a_next = bus.imm;
            A_SEL_PKT: w_a_next = bus.packet_data;
            A_SEL_LEN: w_a_next = bus.packet_len;
            A_SEL_SCR: w_a_next = w_scr_rd;
            A_SEL_ALU: w_a_next = bus.alu_result;
            A_SEL_X:   w_a_next = r_x;
            default:   w_a_next = r_a;
        endcase
    end

    always_comb begin
        w_x_next = r_x;
        case (bus.X_sel)
            X_SEL_IMM: w_x_next = bus.imm;
            X_SEL_PKT: w_x_next = bus.packet_data;
            X_SEL_LEN: w_x_next = bus.packet_len;
            X_SEL_SCR: w_x_next = w_scr_rd;
            X_SEL_A:   w_x_next = r_a;
            X_SEL_MSH: w_x_next = msh(bus.packet_data[3:0]);
            default:   w_x_next = r_x;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a       <= '0;
            r_x       <= '0;
            r_retired <= '0;
        end else begin
            if (w_ld_a) begin
                r_a <= w_a_next;
            end
            if (w_ld_x) begin
                r_x <= w_x_next;
            end
            if (bus.valid && (r_retired != {C_DATA_W{1'b1}})) begin
                r_retired <= r_retired + {{(C_DATA_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.A               = r_a;
    assign bus.X               = r_x;
    assign bus.retired         = r_retired;
    assign bus.scratch_rd_data = w_scr_rd;

endmodule
`default_nettype wire
